inst_mem_loader: RTL and testbench
==================================

INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 The module SHALL have parameter MEM_WORDS, default 64: instruction memory capacity in 32-bit words.
REQ-002 The module SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of the first loaded word.
REQ-003 The module SHALL have port Clock, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The module SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port start, input, 1 bit: single-cycle pulse that begins a load.
REQ-006 The module SHALL have port byte_valid, input, 1 bit: byte_data holds a valid byte.
REQ-007 The module SHALL have port byte_data, input, 8 bits: load stream byte.
REQ-008 The module SHALL have port byte_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-009 The module SHALL have port mem_we, output, 1 bit: instruction memory write enable.
REQ-010 The module SHALL have port mem_addr, output, 32 bits: byte address, word aligned.
REQ-011 The module SHALL have port mem_wdata, output, 32 bits: the instruction word.
REQ-012 The module SHALL have port cpu_hold, output, 1 bit: keeps Fetch_Instruction in reset, PC at BASE_ADDR.
REQ-013 The module SHALL have port done, output, 1 bit: the load completed.
REQ-014 The module SHALL have port err, output, 1 bit: the header length exceeds MEM_WORDS.

Function
REQ-015 A byte SHALL transfer only on a cycle where byte_valid and byte_ready are both 1.
REQ-016 The FSM SHALL have states IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR.
REQ-017 byte_ready SHALL be 1 only in LEN_HI, LEN_LO and DATA.
REQ-018 IDLE, DONE or ERROR plus start SHALL go to LEN_HI, clear word_idx and byte_cnt, clear done and err, and set cpu_hold=1.
REQ-019 start SHALL be ignored in LEN_HI, LEN_LO, DATA and WRITE.
REQ-020 The stream SHALL be a 16-bit word count, MSB first, then count x 4 instruction bytes, big-endian (first byte goes to bits 31:24).
REQ-021 LEN_LO transfer SHALL go to DONE if length==0, to ERROR if length>MEM_WORDS, and to DATA otherwise.
REQ-022 DATA SHALL shift each accepted byte into a 32-bit assembly register; the 4th byte SHALL go to WRITE.
REQ-023 WRITE SHALL last exactly one cycle: mem_we=1, mem_addr=BASE_ADDR+4*word_idx, mem_wdata=assembled word.
REQ-024 WRITE SHALL then increment word_idx and go to DONE if word_idx+1==length, else to DATA.
REQ-025 mem_addr and mem_wdata SHALL be registered, and mem_we SHALL be 0 in every state other than WRITE.
REQ-026 Latency from the 4th byte handshake to mem_we=1 SHALL be exactly 1 cycle.
REQ-027 Sustained throughput SHALL be one word per 5 cycles.
REQ-028 word_idx SHALL be 16 bits; the address SHALL be computed in 32 bits with wrap modulo 2^32 and no saturation.
REQ-029 DONE SHALL drive done=1 and cpu_hold=0 from the cycle of entry.
REQ-030 ERROR SHALL drive err=1 and cpu_hold=1, and SHALL perform no further memory writes.
REQ-031 Idle gaps (byte_valid=0) SHALL stall the FSM with no state or counter change.
REQ-032 There SHALL be no timeout.

Reset
REQ-033 Reset=1 SHALL force IDLE at the next edge in any state, including mid-word.
REQ-034 Reset SHALL force byte_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=1, done=0, err=0, and clear word_idx and byte_cnt.
REQ-035 A partially assembled word SHALL be discarded on reset and never written.
REQ-036 Reset SHALL have priority over start.

Structure
REQ-037 The shared package SHALL hold the state encoding constants, WORD_W=32, and LEN_W=16, shared with the fetch/memory blocks.
REQ-038 Byte-to-word assembly SHALL be one sub-module, word_assembler, with ports: byte in/strobe, clear, word out, word_full.
REQ-039 The FSM, counters and memory port SHALL reside in inst_mem_loader.

Verification
REQ-040 Reset, then start and the bytes 00 02 20 08 00 05 AC 08 00 00 SHALL produce two writes: (0x0, 0x20080005) and (0x4, 0xAC080000), then done=1 and cpu_hold=0.
REQ-041 Start with length 00 00 SHALL give DONE the cycle after LEN_LO with no mem_we pulse.
REQ-042 Length 00 41 with MEM_WORDS=64 SHALL give err=1, cpu_hold=1, and byte_ready=0 thereafter.
REQ-043 Reset asserted after 2 data bytes SHALL give no write and all outputs at reset values; a following start SHALL load cleanly.
REQ-044 byte_valid toggled randomly SHALL give an identical write sequence, with mem_we exactly 1 cycle after each 4th accepted byte.
REQ-045 A start pulse mid-load SHALL be ignored, and after done a second start SHALL re-raise cpu_hold and overwrite from BASE_ADDR.

Source files
------------

// File: rtl/inst_mem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader,
// also used by the fetch and memory blocks.
package inst_mem_loader_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned LEN_W          = 16;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BCNT_W         = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } load_state_e;

    // Byte address of word idx; wraps modulo 2^32 by construction.
    function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] base,
                                                    input logic [LEN_W-1:0]  idx);
        return base + (WORD_W'(idx) << 2);
    endfunction

endpackage

// File: rtl/inst_mem_loader_word_assembler.sv
// Big-endian byte-to-word assembler: bytes shift in at the LSB end, so the
// first of four bytes lands in bits 31:24. word_full pulses for the one
// cycle after the fourth byte is taken.
module word_assembler
    import inst_mem_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              strobe_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_full_o
);

    logic [WORD_W-1:0] word_q;
    logic [BCNT_W-1:0] fill_q;
    logic              full_q;

    // Shift register, fill count and one-cycle full flag.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            word_q <= '0;
            fill_q <= '0;
            full_q <= 1'b0;
        end else begin
            full_q <= 1'b0;
            if (strobe_i) begin
                word_q <= {word_q[WORD_W-BYTE_W-1:0], byte_i};
                fill_q <= fill_q + BCNT_W'(1);
                full_q <= (fill_q == BCNT_W'(BYTES_PER_WORD - 1));
            end
        end
    end

    assign word_o      = word_q;
    assign word_full_o = full_q;

endmodule

// File: rtl/inst_mem_loader.sv
// Boot-time instruction loader: parses a length-prefixed byte stream and
// writes the words into instruction memory while holding the CPU in reset.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int unsigned       MEM_WORDS = 64,
    parameter logic [WORD_W-1:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    load_state_e       state_q;
    logic              byte_ready_q;
    logic [WORD_W-1:0] mem_addr_q;
    logic              cpu_hold_q;
    logic              done_q;
    logic              err_q;
    logic [LEN_W-1:0]  word_idx_q;
    logic [LEN_W-1:0]  len_q;
    logic [BCNT_W-1:0] byte_cnt_q;

    logic              xfer;
    logic              start_ok;
    logic              asm_strobe;
    logic [LEN_W-1:0]  len_full;
    logic [WORD_W-1:0] asm_word;
    logic              asm_full;

    // Handshake, start acceptance and the complete length once LEN_LO lands.
    assign xfer       = byte_valid && byte_ready_q;
    assign start_ok   = start && (state_q inside {IDLE, DONE, ERROR});
    assign asm_strobe = xfer && (state_q == DATA);
    assign len_full   = {len_q[LEN_W-1:BYTE_W], byte_data};

    word_assembler u_asm (
        .clk_i       (Clock),
        .rst_i       (Reset),
        .clear_i     (start_ok),
        .strobe_i    (asm_strobe),
        .byte_i      (byte_data),
        .word_o      (asm_word),
        .word_full_o (asm_full)
    );

    // Load FSM with registered outputs, counters and address register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= IDLE;
            byte_ready_q <= 1'b0;
            mem_addr_q   <= BASE_ADDR;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            word_idx_q   <= '0;
            len_q        <= '0;
            byte_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state_q      <= LEN_HI;
                        byte_ready_q <= 1'b1;
                        cpu_hold_q   <= 1'b1;
                        done_q       <= 1'b0;
                        err_q        <= 1'b0;
                        word_idx_q   <= '0;
                        byte_cnt_q   <= '0;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len_q[LEN_W-1:BYTE_W] <= byte_data;
                        state_q               <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        len_q <= len_full;
                        if (len_full == '0) begin
                            state_q      <= DONE;
                            byte_ready_q <= 1'b0;
                            done_q       <= 1'b1;
                            cpu_hold_q   <= 1'b0;
                        end else if (32'(len_full) > MEM_WORDS) begin
                            state_q      <= ERROR;
                            byte_ready_q <= 1'b0;
                            err_q        <= 1'b1;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        byte_cnt_q <= byte_cnt_q + BCNT_W'(1);
                        if (byte_cnt_q == BCNT_W'(BYTES_PER_WORD - 1)) begin
                            state_q      <= WRITE;
                            byte_ready_q <= 1'b0;
                            mem_addr_q   <= word_addr(BASE_ADDR, word_idx_q);
                        end
                    end
                end
                WRITE: begin
                    word_idx_q <= word_idx_q + LEN_W'(1);
                    if (word_idx_q + LEN_W'(1) == len_q) begin
                        state_q    <= DONE;
                        done_q     <= 1'b1;
                        cpu_hold_q <= 1'b0;
                    end else begin
                        state_q      <= DATA;
                        byte_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    byte_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // The assembler's full flag is registered and high exactly in WRITE.
    assign byte_ready = byte_ready_q;
    assign mem_we     = asm_full;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = asm_word;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: the driver pushes expected writes,
// a negedge monitor pops and compares whenever mem_we is seen.
module tb_inst_mem_loader;

    localparam int unsigned MEMW = 64;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    inst_mem_loader #(.MEM_WORDS(MEMW), .BASE_ADDR(BASE)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] prog[$];
    int          tests = 0;
    int          fails = 0;
    bit          stalled = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write must match the next expected one, on the right cycle.
    always @(negedge Clock) begin
        if (mem_we !== 1'b0) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_write: got we=%b addr=%h data=%h expected no write", mem_we, mem_addr, mem_wdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wr_addr", mem_addr, e.addr);
                check("wr_data", mem_wdata, e.data);
                check("wr_latency_cyc", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Offer one byte until it is accepted; gaps randomly drop byte_valid.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit hs;
        if (stalled) return;
        for (int t = 0; t < 200; t++) begin
            byte_data  = b;
            byte_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            hs         = byte_valid && (byte_ready === 1'b1);
            tick();
            if (hs) begin
                byte_valid = 1'b0;
                return;
            end
        end
        byte_valid = 1'b0;
        stalled    = 1'b1;
        tests++;
        fails++;
        $display("FAIL byte_accept_timeout: got no handshake expected handshake within 200 cycles");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_mem_we"},     32'(mem_we),     32'd0);
        check({tag, "_mem_addr"},   mem_addr,        BASE);
        check({tag, "_mem_wdata"},  mem_wdata,       32'd0);
        check({tag, "_cpu_hold"},   32'(cpu_hold),   32'd1);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_err"},        32'(err),        32'd0);
    endtask

    // Load prog[] with header len; the model expects write i at BASE+4*i.
    task automatic run_load(input logic [15:0] len, input bit gaps, input bit mid_start);
        logic [31:0] w;
        int          last_hs;
        last_hs = 0;
        pulse_start();
        check("start_cpu_hold", 32'(cpu_hold), 32'd1);
        check("start_ready", 32'(byte_ready), 32'd1);
        check("start_done_clr", 32'(done), 32'd0);
        send_byte(len[15:8], gaps);
        send_byte(len[7:0], gaps);
        if (stalled) return;
        if (len == 16'd0) begin
            check("len0_done", 32'(done), 32'd1);
            check("len0_cpu_hold", 32'(cpu_hold), 32'd0);
            check("len0_ready", 32'(byte_ready), 32'd0);
            return;
        end
        if (32'(len) > MEMW) begin
            byte_valid = 1'b1;
            for (int k = 0; k < 6; k++) begin
                check("err_flag", 32'(err), 32'd1);
                check("err_cpu_hold", 32'(cpu_hold), 32'd1);
                check("err_ready", 32'(byte_ready), 32'd0);
                tick();
            end
            byte_valid = 1'b0;
            return;
        end
        for (int i = 0; i < int'(len); i++) begin
            w = prog[i];
            for (int b = 0; b < 4; b++) begin
                send_byte(w[8*(3-b) +: 8], gaps);
                if (stalled) return;
                if (b == 3) begin
                    exp_q.push_back('{addr: BASE + 32'(4 * i), data: w, cyc: cyc});
                    if (!gaps && !mid_start && i > 0)
                        check("throughput_cycles", 32'(cyc - last_hs), 32'd5);
                    last_hs = cyc;
                end
                if (mid_start && i == 0 && b == 1) begin
                    pulse_start();
                    check("mid_start_hold", 32'(cpu_hold), 32'd1);
                end
            end
        end
        for (int t = 0; t < 20 && done !== 1'b1; t++) tick();
        check("end_done", 32'(done), 32'd1);
        check("end_cpu_hold", 32'(cpu_hold), 32'd0);
        check("end_err", 32'(err), 32'd0);
        check("end_ready", 32'(byte_ready), 32'd0);
        check("end_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic random_prog(input int n);
        prog.delete();
        for (int i = 0; i < n; i++) prog.push_back($urandom());
    endtask

    initial begin
        Reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) tick();
        check_reset_outputs("rst");
        Reset = 1'b0;
        tick();

        // Reference program: two words.
        prog.delete();
        prog.push_back(32'h2008_0005);
        prog.push_back(32'hAC08_0000);
        run_load(16'd2, 1'b0, 1'b0);

        // Empty load and oversize header.
        run_load(16'd0, 1'b0, 1'b0);
        run_load(16'h0041, 1'b0, 1'b0);

        // Reset after two data bytes discards the partial word.
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        Reset = 1'b1;
        tick();
        check_reset_outputs("midrst");
        Reset = 1'b0;
        tick();
        check_reset_outputs("postrst");
        random_prog(3);
        run_load(16'd3, 1'b0, 1'b0);

        // Random programs with random byte_valid gaps.
        for (int r = 0; r < 6; r++) begin
            random_prog(int'($urandom_range(1, 6)));
            run_load(16'(prog.size()), 1'b1, 1'b0);
        end

        // Start mid-load ignored, then a second load overwrites from BASE.
        random_prog(3);
        run_load(16'd3, 1'b1, 1'b1);
        random_prog(2);
        run_load(16'd2, 1'b0, 1'b0);

        // Full-capacity boundary.
        random_prog(int'(MEMW));
        run_load(16'(MEMW), 1'b0, 1'b0);

        repeat (10) tick();
        check("leftover_writes", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
